// File: rtl/wb_pkg.sv
// Shared writeback types: result-source select codes and the queued entry layout.
package wb_pkg;

   localparam int unsigned WB_XLEN       = 32;
   localparam int unsigned WB_REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      RESULT_ALU      = 3'd0,
      RESULT_MEM_DATA = 3'd1,
      RESULT_PCPLUS4  = 3'd2,
      RESULT_PCTARGET = 3'd3,
      RESULT_IMM_EXT  = 3'd4
   } result_src_e;

   typedef struct packed {
      logic [WB_XLEN-1:0]       result;
      logic [WB_REG_ADDR_W-1:0] rd;
      logic                     we;
   } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// In-order FIFO of writeback entries; exposes its storage and read pointer so the
// owner can derive per-slot occupancy.
module wb_queue
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type entry_t = wb_entry_t,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  entry_t           wdata_i,
   input  logic             pop_i,
   output entry_t           rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W:0]   count_o,
   output logic [PTR_W-1:0] rd_ptr_o,
   output entry_t           entries_o [DEPTH]
);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   // Storage is not reset: slots outside the occupied window are never observed.
   always_ff @(posedge clk_i) begin
      if (push_i) mem[wr_ptr] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_i) wr_ptr <= wr_ptr + 1'b1;
         if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata_o   = mem[rd_ptr];
   assign full_o    = (count == (PTR_W+1)'(DEPTH));
   assign empty_o   = (count == '0);
   assign count_o   = count;
   assign rd_ptr_o  = rd_ptr;
   assign entries_o = mem;

endmodule

// File: rtl/writeback_commit_queue.sv
// Writeback stage: selects the M-stage result, buffers it in an in-order queue and
// drains one entry per cycle to the register-file write port.
module writeback_commit_queue
   import wb_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CNT_W      = 64
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     valid_m_i,
   input  logic [XLEN-1:0]          alu_result_m_i,
   input  logic [XLEN-1:0]          reduced_data_m_i,
   input  logic [XLEN-1:0]          pc_target_m_i,
   input  logic [XLEN-1:0]          pc_plus4_m_i,
   input  logic [XLEN-1:0]          imm_ext_m_i,
   input  logic [REG_ADDR_W-1:0]    rd_m_i,
   input  logic [2:0]               result_src_m_i,
   input  logic                     reg_write_m_i,
   input  logic                     stall_w_i,
   input  logic                     flush_w_i,
   input  logic                     wr_ready_i,
   output logic [XLEN-1:0]          result_w_o,
   output logic [REG_ADDR_W-1:0]    rd_w_o,
   output logic                     reg_write_w_o,
   output logic                     stall_o,
   output logic [2**REG_ADDR_W-1:0] pending_mask_o,
   output logic [CNT_W-1:0]         retire_count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0]       result;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
   } entry_t;

   entry_t           new_entry;
   entry_t           head;
   entry_t           entries [DEPTH];
   logic             full;
   logic             empty;
   logic [PTR_W:0]   count;
   logic [PTR_W-1:0] rd_ptr;
   logic             enq;
   logic             deq;
   logic [XLEN-1:0]  sel_result;

   always_comb begin
      sel_result = '0;
      case (result_src_m_i)
         RESULT_ALU:      sel_result = alu_result_m_i;
         RESULT_MEM_DATA: sel_result = reduced_data_m_i;
         RESULT_PCPLUS4:  sel_result = pc_plus4_m_i;
         RESULT_PCTARGET: sel_result = pc_target_m_i;
         RESULT_IMM_EXT:  sel_result = imm_ext_m_i;
         default:         sel_result = '0;
      endcase
   end

   assign new_entry.result = sel_result;
   assign new_entry.rd     = rd_m_i;
   assign new_entry.we     = reg_write_m_i && (rd_m_i != '0);

   // full is registered state, so a same-cycle pop never admits a push.
   assign enq = valid_m_i && !flush_w_i && !stall_w_i && !full;
   assign deq = !empty && (!head.we || wr_ready_i);

   wb_queue #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_queue (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .push_i    (enq),
      .wdata_i   (new_entry),
      .pop_i     (deq),
      .rdata_o   (head),
      .full_o    (full),
      .empty_o   (empty),
      .count_o   (count),
      .rd_ptr_o  (rd_ptr),
      .entries_o (entries)
   );

   assign result_w_o    = empty ? '0 : head.result;
   assign rd_w_o        = empty ? '0 : head.rd;
   assign reg_write_w_o = !empty && head.we && wr_ready_i;
   assign stall_o       = full;

   // A slot is occupied when its distance from the read pointer is below count.
   always_comb begin
      logic [PTR_W-1:0] off;
      pending_mask_o = '0;
      off            = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off = PTR_W'(i) - rd_ptr;
         if (({1'b0, off} < count) && entries[i].we)
            pending_mask_o[entries[i].rd] = 1'b1;
      end
      pending_mask_o[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)  retire_count_o <= '0;
      else if (deq)  retire_count_o <= retire_count_o + CNT_W'(1);
   end

endmodule

// File: tb/tb_writeback_commit_queue.sv
// Directed self-checking bench for writeback_commit_queue.
module tb_writeback_commit_queue;
   import wb_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        valid_m_i;
   logic [31:0] alu_result_m_i, reduced_data_m_i, pc_target_m_i, pc_plus4_m_i, imm_ext_m_i;
   logic [4:0]  rd_m_i;
   logic [2:0]  result_src_m_i;
   logic        reg_write_m_i, stall_w_i, flush_w_i, wr_ready_i;
   logic [31:0] result_w_o;
   logic [4:0]  rd_w_o;
   logic        reg_write_w_o, stall_o;
   logic [31:0] pending_mask_o;
   logic [63:0] retire_count_o;

   int tests = 0;
   int fails = 0;

   writeback_commit_queue #(
      .XLEN       (32),
      .REG_ADDR_W (5),
      .DEPTH      (4),
      .CNT_W      (64)
   ) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .valid_m_i        (valid_m_i),
      .alu_result_m_i   (alu_result_m_i),
      .reduced_data_m_i (reduced_data_m_i),
      .pc_target_m_i    (pc_target_m_i),
      .pc_plus4_m_i     (pc_plus4_m_i),
      .imm_ext_m_i      (imm_ext_m_i),
      .rd_m_i           (rd_m_i),
      .result_src_m_i   (result_src_m_i),
      .reg_write_m_i    (reg_write_m_i),
      .stall_w_i        (stall_w_i),
      .flush_w_i        (flush_w_i),
      .wr_ready_i       (wr_ready_i),
      .result_w_o       (result_w_o),
      .rd_w_o           (rd_w_o),
      .reg_write_w_o    (reg_write_w_o),
      .stall_o          (stall_o),
      .pending_mask_o   (pending_mask_o),
      .retire_count_o   (retire_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic bundle(input logic v, input logic [2:0] src, input logic [4:0] rd,
                         input logic we, input logic [31:0] res);
      valid_m_i      = v;
      result_src_m_i = src;
      rd_m_i         = rd;
      reg_write_m_i  = we;
      alu_result_m_i = res;
   endtask

   initial begin
      // Reset with random inputs
      reset_i          = 1'b0;
      valid_m_i        = 1'($urandom);
      alu_result_m_i   = $urandom;
      reduced_data_m_i = $urandom;
      pc_target_m_i    = $urandom;
      pc_plus4_m_i     = $urandom;
      imm_ext_m_i      = $urandom;
      rd_m_i           = 5'($urandom);
      result_src_m_i   = 3'($urandom);
      reg_write_m_i    = 1'($urandom);
      stall_w_i        = 1'($urandom);
      flush_w_i        = 1'($urandom);
      wr_ready_i       = 1'($urandom);
      repeat (3) tick();
      check("rst_result", 64'(result_w_o), 64'h0);
      check("rst_rd", 64'(rd_w_o), 64'h0);
      check("rst_we", 64'(reg_write_w_o), 64'h0);
      check("rst_stall", 64'(stall_o), 64'h0);
      check("rst_mask", 64'(pending_mask_o), 64'h0);
      check("rst_retire", retire_count_o, 64'h0);

      stall_w_i = 1'b0;
      flush_w_i = 1'b0;
      wr_ready_i = 1'b1;
      bundle(1'b0, RESULT_ALU, 5'd0, 1'b0, 32'h0);
      #2 reset_i = 1'b1;
      tick();
      check("post_rst_empty_we", 64'(reg_write_w_o), 64'h0);

      // First bundle: ALU rd=5
      bundle(1'b1, RESULT_ALU, 5'd5, 1'b1, 32'h1234);
      tick();
      check("first_we", 64'(reg_write_w_o), 64'h1);
      check("first_result", 64'(result_w_o), 64'h1234);
      check("first_rd", 64'(rd_w_o), 64'h5);
      check("first_mask", 64'(pending_mask_o), 64'h20);
      valid_m_i = 1'b0;
      tick();
      check("first_retire", retire_count_o, 64'd1);
      check("first_drained", 64'(reg_write_w_o), 64'h0);

      // Result mux sweep
      alu_result_m_i   = 32'hA;
      pc_target_m_i    = 32'hB;
      pc_plus4_m_i     = 32'hC;
      imm_ext_m_i      = 32'hD;
      reduced_data_m_i = 32'hE;
      valid_m_i = 1'b1; rd_m_i = 5'd3; reg_write_m_i = 1'b1;
      result_src_m_i = RESULT_ALU;      tick(); check("mux_alu", 64'(result_w_o), 64'hA);
      result_src_m_i = RESULT_PCTARGET; tick(); check("mux_pctarget", 64'(result_w_o), 64'hB);
      result_src_m_i = RESULT_PCPLUS4;  tick(); check("mux_pcplus4", 64'(result_w_o), 64'hC);
      result_src_m_i = RESULT_IMM_EXT;  tick(); check("mux_imm", 64'(result_w_o), 64'hD);
      result_src_m_i = RESULT_MEM_DATA; tick(); check("mux_mem", 64'(result_w_o), 64'hE);
      result_src_m_i = 3'd7;            tick(); check("mux_illegal", 64'(result_w_o), 64'h0);
      check("mux_illegal_we", 64'(reg_write_w_o), 64'h1);
      valid_m_i = 1'b0;
      tick();
      check("mux_retire", retire_count_o, 64'd7);

      // Backpressure: fill with rd=1..4 while the write port is busy
      wr_ready_i = 1'b0;
      for (int r = 1; r <= 4; r++) begin
         bundle(1'b1, RESULT_ALU, 5'(r), 1'b1, 32'h100 + 32'(r));
         tick();
      end
      check("bp_stall", 64'(stall_o), 64'h1);
      check("bp_mask", 64'(pending_mask_o), 64'h1E);
      check("bp_we_held", 64'(reg_write_w_o), 64'h0);
      check("bp_head_result", 64'(result_w_o), 64'h101);
      bundle(1'b1, RESULT_ALU, 5'd6, 1'b1, 32'h106);
      tick();
      check("bp_fifth_dropped_mask", 64'(pending_mask_o), 64'h1E);
      check("bp_retire_held", retire_count_o, 64'd7);
      valid_m_i  = 1'b0;
      wr_ready_i = 1'b1;
      #1;
      for (int r = 1; r <= 4; r++) begin
         check("bp_drain_we", 64'(reg_write_w_o), 64'h1);
         check("bp_drain_rd", 64'(rd_w_o), 64'(r));
         check("bp_drain_result", 64'(result_w_o), 64'h100 + 64'(r));
         tick();
      end
      check("bp_empty_we", 64'(reg_write_w_o), 64'h0);
      check("bp_stall_clear", 64'(stall_o), 64'h0);
      check("bp_retire", retire_count_o, 64'd11);

      // x0 write and non-write bundles drain without the write port
      wr_ready_i = 1'b0;
      bundle(1'b1, RESULT_ALU, 5'd0, 1'b1, 32'h55);
      tick();
      check("x0_we", 64'(reg_write_w_o), 64'h0);
      check("x0_mask", 64'(pending_mask_o), 64'h0);
      check("x0_result", 64'(result_w_o), 64'h55);
      bundle(1'b1, RESULT_ALU, 5'd7, 1'b0, 32'h77);
      tick();
      check("nowr_we", 64'(reg_write_w_o), 64'h0);
      check("nowr_mask", 64'(pending_mask_o), 64'h0);
      check("nowr_rd", 64'(rd_w_o), 64'h7);
      valid_m_i = 1'b0;
      tick();
      check("nowr_retire", retire_count_o, 64'd13);
      check("nowr_empty_rd", 64'(rd_w_o), 64'h0);

      // Flush and stall both suppress enqueue
      wr_ready_i = 1'b1;
      bundle(1'b1, RESULT_ALU, 5'd9, 1'b1, 32'h99);
      flush_w_i = 1'b1;
      tick();
      check("flush_we", 64'(reg_write_w_o), 64'h0);
      check("flush_mask", 64'(pending_mask_o), 64'h0);
      flush_w_i = 1'b0;
      stall_w_i = 1'b1;
      tick();
      check("stall_we", 64'(reg_write_w_o), 64'h0);
      check("stall_result", 64'(result_w_o), 64'h0);
      stall_w_i = 1'b0;
      valid_m_i = 1'b0;
      tick();
      check("flush_stall_retire", retire_count_o, 64'd13);

      // Steady stream across pointer wrap, then async reset mid-stream
      for (int i = 0; i < 10; i++) begin
         bundle(1'b1, RESULT_ALU, 5'(i + 1), 1'b1, 32'h2000 + 32'(i));
         tick();
         check("stream_we", 64'(reg_write_w_o), 64'h1);
         check("stream_rd", 64'(rd_w_o), 64'(i + 1));
         check("stream_result", 64'(result_w_o), 64'h2000 + 64'(i));
         check("stream_stall", 64'(stall_o), 64'h0);
      end
      check("stream_retire", retire_count_o, 64'd22);
      bundle(1'b1, RESULT_ALU, 5'd11, 1'b1, 32'h200A);
      tick();
      check("stream_last_we", 64'(reg_write_w_o), 64'h1);
      #2 reset_i = 1'b0;
      #1;
      check("midrst_we", 64'(reg_write_w_o), 64'h0);
      check("midrst_result", 64'(result_w_o), 64'h0);
      check("midrst_mask", 64'(pending_mask_o), 64'h0);
      check("midrst_retire", retire_count_o, 64'h0);
      tick();
      check("midrst_held_we", 64'(reg_write_w_o), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
